// File: rtl/alu_vector_sequencer.sv
// Vector sequencer: feeds LANES packed operands one lane per cycle through a shared
// external combinational ALU and gathers the per-lane results and accumulated flags.
module alu_vector_sequencer #(
   parameter int BITS  = 64,
   parameter int LANES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic [1:0]            op,
   input  logic [LANES*BITS-1:0] vec_a,
   input  logic [LANES*BITS-1:0] vec_b,
   output logic [BITS-1:0]       alu_src_a,
   output logic [BITS-1:0]       alu_src_b,
   output logic [1:0]            alu_control,
   input  logic [BITS-1:0]       alu_result,
   input  logic [3:0]            alu_flags,
   output logic                  done_valid,
   input  logic                  done_ready,
   output logic [LANES*BITS-1:0] vec_result,
   output logic [3:0]            flags_acc,
   output logic                  busy
);

   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state;
   logic [LW-1:0]           lane_idx;
   logic [LANES*BITS-1:0]   a_reg;
   logic [LANES*BITS-1:0]   b_reg;
   logic [1:0]              op_reg;

   // Reset aborts any op in flight; the last lane parks the index instead of wrapping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         lane_idx   <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         op_reg     <= 2'b00;
         vec_result <= '0;
         flags_acc  <= 4'b0001;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  a_reg      <= vec_a;
                  b_reg      <= vec_b;
                  op_reg     <= op;
                  lane_idx   <= '0;
                  vec_result <= '0;
                  flags_acc  <= 4'b0001;
                  state      <= RUN;
               end
            end
            RUN: begin
               vec_result[lane_idx*BITS +: BITS] <= alu_result;
               flags_acc[3:1] <= flags_acc[3:1] | alu_flags[3:1];
               flags_acc[0]   <= flags_acc[0] & alu_flags[0];
               if (lane_idx == LAST_LANE) begin
                  state <= DONE;
               end else begin
                  lane_idx <= lane_idx + 1'b1;
               end
            end
            DONE: begin
               if (done_ready) begin
                  state    <= IDLE;
                  lane_idx <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      alu_src_a   = '0;
      alu_src_b   = '0;
      alu_control = 2'b00;
      if (state == RUN) begin
         alu_src_a   = a_reg[lane_idx*BITS +: BITS];
         alu_src_b   = b_reg[lane_idx*BITS +: BITS];
         alu_control = op_reg;
      end
   end

   assign start_ready = rst_n && (state == IDLE);
   assign done_valid  = (state == DONE);
   assign busy        = (state != IDLE);

endmodule
